// File: rtl/agdc_supervisor.sv
// Garage-door motor sequencer: request merge, reversal dead-time, obstruction reversal and fault latch.
// Optional auto-close from the open limit is compiled in with `define AGDC_AUTOCLOSE_EN.
module agdc_supervisor #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned DEAD_CYC      = 4,
  parameter int unsigned TRAVEL_MAX    = 1000,
  parameter int unsigned AUTOCLOSE_CYC = 5000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_Wall,
  input  logic BTN_Remote,
  input  logic UP_Max,
  input  logic DN_Max,
  input  logic Obstruct,
  output logic UP_M,
  output logic DN_M,
  output logic Busy,
  output logic Fault
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StOpening = 3'd1;
  localparam logic [2:0] StClosing = 3'd2;
  localparam logic [2:0] StDead    = 3'd3;
  localparam logic [2:0] StFault   = 3'd4;

  localparam logic DirClose = 1'b0;
  localparam logic DirOpen  = 1'b1;

  localparam logic [CNT_W-1:0] DeadLast   = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
`ifdef AGDC_AUTOCLOSE_EN
  localparam logic [CNT_W-1:0] AcLast     = CNT_W'(AUTOCLOSE_CYC - 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             dir_q, dir_d;
  logic             pend_q, pend_d;
  logic             wall_q, remote_q;
  logic             req, go, both_max;

  assign req      = (BTN_Wall & ~wall_q) | (BTN_Remote & ~remote_q);
  assign both_max = UP_Max & DN_Max;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    dir_d   = dir_q;
    pend_d  = pend_q;
    go      = req;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
`ifdef AGDC_AUTOCLOSE_EN
        if (UP_Max && !Obstruct && !req) begin
          cnt_d = cnt_inc;
          go    = (cnt_q == AcLast);
        end
`endif
        if (both_max) begin
          state_d = StFault;
        end else if (go) begin
          if (UP_Max) begin
            if (!Obstruct) state_d = StClosing;
          end else if (DN_Max) begin
            state_d = StOpening;
          end else if (dir_q == DirClose) begin
            state_d = StOpening;
          end else if (!Obstruct) begin
            state_d = StClosing;
          end
        end
      end
      StOpening: begin
        if (both_max) begin
          state_d = StFault;
        end else if (UP_Max) begin
          state_d = StIdle;
        end else if (cnt_q == TravelLast) begin
          state_d = StFault;
        end else if (req) begin
          state_d = StDead;
          pend_d  = DirClose;
        end
      end
      StClosing: begin
        if (both_max) begin
          state_d = StFault;
        end else if (Obstruct) begin
          state_d = StDead;
          pend_d  = DirOpen;
        end else if (DN_Max) begin
          state_d = StIdle;
        end else if (cnt_q == TravelLast) begin
          state_d = StFault;
        end else if (req) begin
          state_d = StDead;
          pend_d  = DirOpen;
        end
      end
      StDead: begin
        if (both_max) begin
          state_d = StFault;
        end else if (cnt_q == DeadLast) begin
          if (pend_q == DirOpen)  state_d = StOpening;
          else if (Obstruct)      state_d = StIdle;
          else                    state_d = StClosing;
        end
      end
      StFault: cnt_d = cnt_q;
      default: state_d = StFault;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Direction memory tracks the last motion actually started.
    if (state_d == StOpening) dir_d = DirOpen;
    if (state_d == StClosing) dir_d = DirClose;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dir_q    <= DirClose;
      pend_q   <= DirClose;
      wall_q   <= 1'b0;
      remote_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      wall_q   <= BTN_Wall;
      remote_q <= BTN_Remote;
    end
  end

  assign UP_M  = (state_q == StOpening);
  assign DN_M  = (state_q == StClosing);
  assign Busy  = (state_q == StOpening) | (state_q == StClosing) | (state_q == StDead);
  assign Fault = (state_q == StFault);

endmodule

// File: tb/tb_agdc_supervisor.sv
// Directed bench for agdc_supervisor: a step table for the main sequence plus hand sequences
// for travel timeout, async reset mid-travel and (when compiled in) auto-close.
module tb_agdc_supervisor;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic BTN_Wall = 1'b0, BTN_Remote = 1'b0, UP_Max = 1'b0, DN_Max = 1'b0, Obstruct = 1'b0;
  logic UP_M, DN_M, Busy, Fault;

  int n_checks = 0;
  int n_fail   = 0;

  agdc_supervisor #(
    .CNT_W        (16),
    .DEAD_CYC     (4),
    .TRAVEL_MAX   (1000),
    .AUTOCLOSE_CYC(20)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_Wall  (BTN_Wall),
    .BTN_Remote(BTN_Remote),
    .UP_Max    (UP_Max),
    .DN_Max    (DN_Max),
    .Obstruct  (Obstruct),
    .UP_M      (UP_M),
    .DN_M      (DN_M),
    .Busy      (Busy),
    .Fault     (Fault)
  );

  always #5 CLK = ~CLK;

  // in = {wall, remote, up_max, dn_max, obstruct}; exp = {UP_M, DN_M, Busy, Fault}
  typedef struct packed {
    logic [4:0] in;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [0:39];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    n_checks++;
    if ({UP_M, DN_M, Busy, Fault} !== exp) begin
      n_fail++;
      $display("FAIL %s: {UP_M,DN_M,Busy,Fault} got %b expected %b", name,
               {UP_M, DN_M, Busy, Fault}, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] v);
    {BTN_Wall, BTN_Remote, UP_Max, DN_Max, Obstruct} = v;
  endtask

  task automatic do_reset(input logic [4:0] v);
    RST = 1'b0;
    set_in(v);
    repeat (2) @(posedge CLK);
    #1;
    check("reset", 4'b0000);
    RST = 1'b1;
  endtask

  initial begin
    int cnt;
    tbl[0]  = {5'b00010, 4'b0000};  // idle, closed
    tbl[1]  = {5'b10010, 4'b1010};  // wall edge at closed limit -> open
    tbl[2]  = {5'b10000, 4'b1010};  // held level, no retrigger
    tbl[3]  = {5'b00000, 4'b1010};
    tbl[4]  = {5'b00100, 4'b0000};  // open limit -> idle
    tbl[5]  = {5'b01100, 4'b0110};  // remote at open limit -> close
    tbl[6]  = {5'b00000, 4'b0110};
    tbl[7]  = {5'b01000, 4'b0010};  // reversal -> dead
    tbl[8]  = {5'b00000, 4'b0010};
    tbl[9]  = {5'b01000, 4'b0010};  // req in dead ignored
    tbl[10] = {5'b00000, 4'b0010};
    tbl[11] = {5'b00000, 4'b1010};  // dead expires -> opening
    tbl[12] = {5'b10000, 4'b0010};  // reversal while opening
    tbl[13] = {5'b00000, 4'b0010};
    tbl[14] = {5'b00000, 4'b0010};
    tbl[15] = {5'b00000, 4'b0010};
    tbl[16] = {5'b00000, 4'b0110};  // -> closing
    tbl[17] = {5'b00001, 4'b0010};  // obstruction while closing
    tbl[18] = {5'b00000, 4'b0010};
    tbl[19] = {5'b00000, 4'b0010};
    tbl[20] = {5'b00000, 4'b0010};
    tbl[21] = {5'b00000, 4'b1010};  // -> opening
    tbl[22] = {5'b00001, 4'b1010};  // obstruction ignored while opening
    tbl[23] = {5'b00100, 4'b0000};
    tbl[24] = {5'b10101, 4'b0000};  // close request blocked by obstruction
    tbl[25] = {5'b00101, 4'b0000};
    tbl[26] = {5'b01100, 4'b0110};
    tbl[27] = {5'b00010, 4'b0000};  // closed limit -> idle
    tbl[28] = {5'b10000, 4'b1010};  // mid-travel, last dir close -> open
    tbl[29] = {5'b00000, 4'b1010};
    tbl[30] = {5'b01000, 4'b0010};  // dead, pending close
    tbl[31] = {5'b00001, 4'b0010};
    tbl[32] = {5'b00001, 4'b0010};
    tbl[33] = {5'b00001, 4'b0010};
    tbl[34] = {5'b00001, 4'b0000};  // obstructed at expiry -> idle
    tbl[35] = {5'b10000, 4'b0110};  // last dir open -> close
    tbl[36] = {5'b00010, 4'b0000};
    tbl[37] = {5'b00110, 4'b0001};  // both limits -> fault
    tbl[38] = {5'b10010, 4'b0001};  // inputs ignored in fault
    tbl[39] = {5'b00000, 4'b0001};

    do_reset(5'b00010);
    for (int i = 0; i < 40; i++) begin
      set_in(tbl[i].in);
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Travel timeout: 1000 motor-on cycles, then latched fault.
    do_reset(5'b00000);
    set_in(5'b10000);
    step();
    check("timeout_start", 4'b1010);
    set_in(5'b00000);
    cnt = 1;
    for (int i = 0; i < 999; i++) begin
      step();
      if (UP_M === 1'b1 && Fault === 1'b0) cnt++;
    end
    check_int("timeout_run_cycles", cnt, 1000);
    step();
    check("timeout_fault", 4'b0001);
    set_in(5'b10010);
    step();
    set_in(5'b01000);
    step();
    check("timeout_req_ignored", 4'b0001);

    // Async reset mid-travel drops the motor without a clock edge.
    do_reset(5'b00010);
    set_in(5'b10010);
    step();
    check("mid_reset_open", 4'b1010);
    #2;
    RST = 1'b0;
    #1;
    check("mid_reset_async", 4'b0000);
    set_in(5'b00000);
    step();
    RST = 1'b1;
    step();
    step();
    check("mid_reset_stays_idle", 4'b0000);
    set_in(5'b10000);
    step();
    check("mid_reset_new_req", 4'b1010);

`ifdef AGDC_AUTOCLOSE_EN
    do_reset(5'b00100);
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (DN_M === 1'b0) cnt++;
    end
    check_int("autoclose_wait", cnt, 19);
    step();
    check("autoclose_fire", 4'b0110);

    do_reset(5'b00100);
    repeat (10) step();
    set_in(5'b00101);
    step();
    check("autoclose_restart_idle", 4'b0000);
    set_in(5'b00100);
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (DN_M === 1'b0) cnt++;
    end
    check_int("autoclose_restart_wait", cnt, 19);
    step();
    check("autoclose_restart_fire", 4'b0110);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
